// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer
// Sequences the duty and direction commands of one DC motor channel. The
// applied duty slews toward the software target at a bounded rate. A direction
// change brakes to zero duty and waits until the measured Hall frequency has
// been zero for a qualified time. Only then is the direction flipped and the
// duty ramped back up.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   enable       run request from software
//   target_duty  requested duty
//   target_dir   requested direction
//   freq         measured motor frequency from the frequency detector
//   duty_out     applied duty, to the PWM generator
//   dir_out      applied direction, to the motor controller
//   busy         high in RAMP, BRAKE, WAIT_STOP and REVERSE
//   fault        stop-wait timeout
//   state        current state register
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | disabled, duty forced to zero
// RAMP      | slewing duty toward target_duty
// HOLD      | duty equals target, waiting for a new request
// BRAKE     | slewing duty toward zero
// WAIT_STOP | duty zero, qualifying freq==0 before a direction flip
// REVERSE   | one cycle, applies the new direction
// FAULT     | motor never stopped, held until enable drops
module motor_ramp_sequencer #(
    parameter int DUTY_WIDTH     = 15,
    parameter int FREQ_WIDTH     = 8,
    parameter int RAMP_DIV       = 100_000,
    parameter int RAMP_STEP      = 256,
    parameter int STOP_CYCLES    = 10_000_000,
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DUTY_WIDTH-1:0] target_duty,
    input  logic                  target_dir,
    input  logic [FREQ_WIDTH-1:0] freq,
    output logic [DUTY_WIDTH-1:0] duty_out,
    output logic                  dir_out,
    output logic                  busy,
    output logic                  fault,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP      = 3'd1,
        S_HOLD      = 3'd2,
        S_BRAKE     = 3'd3,
        S_WAIT_STOP = 3'd4,
        S_REVERSE   = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam int DIV_W  = $clog2(RAMP_DIV + 1);
    localparam int STOP_W = $clog2(STOP_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    // Timers are down-counters: loaded with N-1, terminal count at zero.
    localparam logic [DIV_W-1:0]      DIV_LOAD  = DIV_W'(RAMP_DIV - 1);
    localparam logic [STOP_W-1:0]     STOP_LOAD = STOP_W'(STOP_CYCLES - 1);
    localparam logic [TO_W-1:0]       TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DUTY_WIDTH-1:0] STEP_MAX  = DUTY_WIDTH'(RAMP_STEP);

    state_t                state_q;
    logic [DUTY_WIDTH-1:0] duty_q;
    logic                  dir_q;
    logic                  busy_q;
    logic                  fault_q;
    logic [DIV_W-1:0]      div_cnt;
    logic [STOP_W-1:0]     stop_cnt;
    logic [TO_W-1:0]       to_cnt;

    logic [DUTY_WIDTH-1:0] goal;
    logic [DUTY_WIDTH-1:0] diff;
    logic [DUTY_WIDTH-1:0] step;
    logic [DUTY_WIDTH-1:0] duty_stepped;
    logic                  going_up;
    logic                  tick;
    logic                  dir_match;
    logic                  freq_zero;

    // The difference is formed before stepping and the step is clamped to it,
    // so the duty lands exactly on the goal and can never wrap.
    always_comb begin
        goal         = (state_q == S_BRAKE) ? '0 : target_duty;
        going_up     = (goal >= duty_q);
        diff         = going_up ? (goal - duty_q) : (duty_q - goal);
        step         = (diff > STEP_MAX) ? STEP_MAX : diff;
        duty_stepped = going_up ? (duty_q + step) : (duty_q - step);
    end

    assign tick      = (div_cnt == '0);
    assign dir_match = (target_dir == dir_q);
    assign freq_zero = (freq == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            duty_q   <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            div_cnt  <= '0;
            stop_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    duty_q <= '0;
                    if (enable) begin
                        busy_q <= 1'b1;
                        if (dir_match) begin
                            state_q <= S_RAMP;
                            div_cnt <= DIV_LOAD;
                        end else begin
                            state_q  <= S_WAIT_STOP;
                            stop_cnt <= STOP_LOAD;
                            to_cnt   <= TO_LOAD;
                        end
                    end
                end

                S_RAMP: begin
                    if (!enable || !dir_match) begin
                        state_q <= S_BRAKE;
                        div_cnt <= DIV_LOAD;
                    end else if (duty_q == target_duty) begin
                        state_q <= S_HOLD;
                        busy_q  <= 1'b0;
                    end else begin
                        // Prescaler keeps running across target changes so a
                        // redirect does not restart the tick period.
                        div_cnt <= tick ? DIV_LOAD : div_cnt - 1'b1;
                        if (tick) duty_q <= duty_stepped;
                    end
                end

                S_HOLD: begin
                    if (!enable || !dir_match) begin
                        state_q <= S_BRAKE;
                        busy_q  <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end else if (target_duty != duty_q) begin
                        state_q <= S_RAMP;
                        busy_q  <= 1'b1;
                        div_cnt <= DIV_LOAD;
                    end
                end

                S_BRAKE: begin
                    if (duty_q == '0) begin
                        if (!enable) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else if (!dir_match) begin
                            state_q  <= S_WAIT_STOP;
                            stop_cnt <= STOP_LOAD;
                            to_cnt   <= TO_LOAD;
                        end else begin
                            state_q <= S_RAMP;
                            div_cnt <= DIV_LOAD;
                        end
                    end else begin
                        div_cnt <= tick ? DIV_LOAD : div_cnt - 1'b1;
                        if (tick) duty_q <= duty_stepped;
                    end
                end

                S_WAIT_STOP: begin
                    duty_q <= '0;
                    if (!enable) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (dir_match) begin
                        state_q <= S_RAMP;
                        div_cnt <= DIV_LOAD;
                    end else if (freq_zero && stop_cnt == '0) begin
                        state_q <= S_REVERSE;
                    end else if (to_cnt == '0) begin
                        state_q <= S_FAULT;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        to_cnt   <= to_cnt - 1'b1;
                        // Any motion restarts the zero-frequency qualification.
                        stop_cnt <= freq_zero ? stop_cnt - 1'b1 : STOP_LOAD;
                    end
                end

                S_REVERSE: begin
                    dir_q   <= target_dir;
                    state_q <= S_RAMP;
                    div_cnt <= DIV_LOAD;
                end

                S_FAULT: begin
                    duty_q <= '0;
                    if (!enable) begin
                        state_q <= S_IDLE;
                        fault_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    duty_q  <= '0;
                    busy_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign duty_out = duty_q;
    assign dir_out  = dir_q;
    assign busy     = busy_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed testbench for motor_ramp_sequencer with short timing parameters:
// ramp tick every 4 cycles, step 100, stop qualification 8 cycles, and a
// stop-wait timeout of 64 cycles.
module tb_motor_ramp_sequencer;

    typedef logic [14:0] duty_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RAMP      = 3'd1;
    localparam logic [2:0] ST_HOLD      = 3'd2;
    localparam logic [2:0] ST_BRAKE     = 3'd3;
    localparam logic [2:0] ST_WAIT_STOP = 3'd4;
    localparam logic [2:0] ST_REVERSE   = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    logic        clk;
    logic        reset;
    logic        enable;
    duty_t       target_duty;
    logic        target_dir;
    logic [7:0]  freq;
    duty_t       duty_out;
    logic        dir_out;
    logic        busy;
    logic        fault;
    logic [2:0]  state;

    int vectors;
    int miscompares;

    logic  prev_dir;
    duty_t prev_duty;

    motor_ramp_sequencer #(
        .DUTY_WIDTH    (15),
        .FREQ_WIDTH    (8),
        .RAMP_DIV      (4),
        .RAMP_STEP     (100),
        .STOP_CYCLES   (8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .target_duty(target_duty),
        .target_dir (target_dir),
        .freq       (freq),
        .duty_out   (duty_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .fault      (fault),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direction may only change while the applied duty is zero.
    initial begin
        prev_dir  = 1'b0;
        prev_duty = '0;
    end
    always @(negedge clk) begin
        if (reset && dir_out !== prev_dir) begin
            vectors++;
            if (prev_duty !== '0 || duty_out !== '0) begin
                miscompares++;
                $display("FAIL dir_toggle_with_duty: duty before=%0d after=%0d required 0", prev_duty, duty_out);
            end
        end
        prev_dir  = dir_out;
        prev_duty = duty_out;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; target_duty = '0; target_dir = 1'b0; freq = '0;
        #1 reset = 1'b0;
        #1;
        vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
        vectors++; if (duty_out !== '0) begin miscompares++; $display("FAIL reset_duty got=%0d exp=0", duty_out); end
        vectors++; if (dir_out !== 1'b0) begin miscompares++; $display("FAIL reset_dir got=%0b exp=0", dir_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got=%0b exp=0", fault); end
        cyc(2);
        vectors++; if (state !== ST_IDLE) begin miscompares++; $display("FAIL reset_hold_state got=%0d exp=%0d", state, ST_IDLE); end
    endtask

    task automatic test_ramp_up;
        duty_t exp_up [4] = '{15'd100, 15'd200, 15'd300, 15'd350};
        duty_t prev = '0;
        reset = 1'b1; enable = 1'b1; target_duty = 15'd350; target_dir = 1'b0;
        cyc(1);
        vectors++; if (state !== ST_RAMP || busy !== 1'b1) begin miscompares++; $display("FAIL up_enter state=%0d busy=%0b exp state=1 busy=1", state, busy); end
        for (int i = 0; i < 4; i++) begin
            cyc(3);
            vectors++; if (duty_out !== prev) begin miscompares++; $display("FAIL up_between[%0d] got=%0d exp=%0d", i, duty_out, prev); end
            cyc(1);
            vectors++; if (duty_out !== exp_up[i]) begin miscompares++; $display("FAIL up_step[%0d] got=%0d exp=%0d", i, duty_out, exp_up[i]); end
            prev = exp_up[i];
        end
        cyc(1);
        vectors++; if (state !== ST_HOLD || busy !== 1'b0 || dir_out !== 1'b0) begin miscompares++; $display("FAIL up_hold state=%0d busy=%0b dir=%0b exp 2/0/0", state, busy, dir_out); end
    endtask

    task automatic test_ramp_down;
        duty_t exp_dn [3] = '{15'd250, 15'd150, 15'd50};
        target_duty = 15'd50;
        cyc(1);
        vectors++; if (state !== ST_RAMP) begin miscompares++; $display("FAIL dn_enter got=%0d exp=%0d", state, ST_RAMP); end
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            vectors++; if (duty_out !== exp_dn[i]) begin miscompares++; $display("FAIL dn_step[%0d] got=%0d exp=%0d", i, duty_out, exp_dn[i]); end
        end
        cyc(1);
        vectors++; if (state !== ST_HOLD) begin miscompares++; $display("FAIL dn_hold got=%0d exp=%0d", state, ST_HOLD); end
    endtask

    task automatic test_redirect;
        target_duty = 15'd350;
        cyc(5);
        vectors++; if (duty_out !== 15'd150) begin miscompares++; $display("FAIL redir_first got=%0d exp=150", duty_out); end
        // New goal below the current duty; next tick keeps its original spacing.
        target_duty = 15'd120;
        cyc(3);
        vectors++; if (duty_out !== 15'd150 || state !== ST_RAMP) begin miscompares++; $display("FAIL redir_wait duty=%0d state=%0d exp 150/1", duty_out, state); end
        cyc(1);
        vectors++; if (duty_out !== 15'd120) begin miscompares++; $display("FAIL redir_land got=%0d exp=120", duty_out); end
        cyc(1);
        vectors++; if (state !== ST_HOLD || duty_out !== 15'd120) begin miscompares++; $display("FAIL redir_hold state=%0d duty=%0d exp 2/120", state, duty_out); end
        target_duty = 15'd350;
        cyc(13);
        vectors++; if (duty_out !== 15'd350) begin miscompares++; $display("FAIL redir_back got=%0d exp=350", duty_out); end
        cyc(1);
        vectors++; if (state !== ST_HOLD) begin miscompares++; $display("FAIL redir_back_hold got=%0d exp=%0d", state, ST_HOLD); end
    endtask

    task automatic test_reverse;
        duty_t exp_br [4] = '{15'd250, 15'd150, 15'd50, 15'd0};
        freq = 8'd20; target_dir = 1'b1;
        cyc(1);
        vectors++; if (state !== ST_BRAKE || busy !== 1'b1) begin miscompares++; $display("FAIL rev_brake state=%0d busy=%0b exp 3/1", state, busy); end
        for (int i = 0; i < 4; i++) begin
            cyc(4);
            vectors++; if (duty_out !== exp_br[i]) begin miscompares++; $display("FAIL rev_brake_step[%0d] got=%0d exp=%0d", i, duty_out, exp_br[i]); end
        end
        cyc(1);
        vectors++; if (state !== ST_WAIT_STOP || duty_out !== '0) begin miscompares++; $display("FAIL rev_wait state=%0d duty=%0d exp 4/0", state, duty_out); end
        cyc(5);
        vectors++; if (state !== ST_WAIT_STOP || dir_out !== 1'b0) begin miscompares++; $display("FAIL rev_spinning state=%0d dir=%0b exp 4/0", state, dir_out); end
        freq = 8'd0;
        cyc(7);
        vectors++; if (state !== ST_WAIT_STOP) begin miscompares++; $display("FAIL rev_7zero got=%0d exp=%0d", state, ST_WAIT_STOP); end
        cyc(1);
        vectors++; if (state !== ST_REVERSE || dir_out !== 1'b0) begin miscompares++; $display("FAIL rev_8zero state=%0d dir=%0b exp 5/0", state, dir_out); end
        cyc(1);
        vectors++; if (state !== ST_RAMP || dir_out !== 1'b1) begin miscompares++; $display("FAIL rev_flip state=%0d dir=%0b exp 1/1", state, dir_out); end
        cyc(16);
        vectors++; if (duty_out !== 15'd350) begin miscompares++; $display("FAIL rev_rampup got=%0d exp=350", duty_out); end
        cyc(1);
        vectors++; if (state !== ST_HOLD || dir_out !== 1'b1) begin miscompares++; $display("FAIL rev_hold state=%0d dir=%0b exp 2/1", state, dir_out); end
    endtask

    task automatic test_stop_glitch;
        freq = 8'd0; target_dir = 1'b0;
        cyc(17);
        vectors++; if (duty_out !== '0 || state !== ST_BRAKE) begin miscompares++; $display("FAIL glitch_brake duty=%0d state=%0d exp 0/3", duty_out, state); end
        cyc(1);
        vectors++; if (state !== ST_WAIT_STOP) begin miscompares++; $display("FAIL glitch_wait got=%0d exp=%0d", state, ST_WAIT_STOP); end
        cyc(6);
        freq = 8'd1;
        cyc(1);
        freq = 8'd0;
        cyc(7);
        vectors++; if (state !== ST_WAIT_STOP || dir_out !== 1'b1) begin miscompares++; $display("FAIL glitch_requal state=%0d dir=%0b exp 4/1", state, dir_out); end
        cyc(1);
        vectors++; if (state !== ST_REVERSE) begin miscompares++; $display("FAIL glitch_reverse got=%0d exp=%0d", state, ST_REVERSE); end
        cyc(1);
        vectors++; if (state !== ST_RAMP || dir_out !== 1'b0) begin miscompares++; $display("FAIL glitch_flip state=%0d dir=%0b exp 1/0", state, dir_out); end
    endtask

    task automatic test_timeout;
        target_dir = 1'b1; freq = 8'd30;
        cyc(1);
        vectors++; if (state !== ST_BRAKE) begin miscompares++; $display("FAIL to_brake got=%0d exp=%0d", state, ST_BRAKE); end
        cyc(1);
        vectors++; if (state !== ST_WAIT_STOP) begin miscompares++; $display("FAIL to_wait got=%0d exp=%0d", state, ST_WAIT_STOP); end
        cyc(63);
        vectors++; if (state !== ST_WAIT_STOP || fault !== 1'b0) begin miscompares++; $display("FAIL to_early state=%0d fault=%0b exp 4/0", state, fault); end
        cyc(1);
        vectors++; if (state !== ST_FAULT || fault !== 1'b1 || duty_out !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL to_fault state=%0d fault=%0b duty=%0d busy=%0b exp 6/1/0/0", state, fault, duty_out, busy); end
        enable = 1'b1; target_dir = 1'b0;
        cyc(3);
        vectors++; if (state !== ST_FAULT || fault !== 1'b1 || dir_out !== 1'b0) begin miscompares++; $display("FAIL to_sticky state=%0d fault=%0b dir=%0b exp 6/1/0", state, fault, dir_out); end
        enable = 1'b0;
        cyc(1);
        vectors++; if (state !== ST_IDLE || fault !== 1'b0) begin miscompares++; $display("FAIL to_clear state=%0d fault=%0b exp 0/0", state, fault); end
    endtask

    task automatic test_async_reset;
        target_dir = 1'b0; target_duty = 15'd350; enable = 1'b1; freq = 8'd0;
        cyc(9);
        vectors++; if (duty_out !== 15'd200) begin miscompares++; $display("FAIL ar_pre got=%0d exp=200", duty_out); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (duty_out !== '0 || state !== ST_IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL ar_async duty=%0d state=%0d busy=%0b exp 0/0/0", duty_out, state, busy); end
        #2 reset = 1'b1;
        cyc(1);
        vectors++; if (state !== ST_RAMP || duty_out !== '0) begin miscompares++; $display("FAIL ar_restart state=%0d duty=%0d exp 1/0", state, duty_out); end
        cyc(8);
        enable = 1'b0;
        cyc(1);
        vectors++; if (state !== ST_BRAKE || duty_out !== 15'd200) begin miscompares++; $display("FAIL dis_brake state=%0d duty=%0d exp 3/200", state, duty_out); end
        cyc(4);
        vectors++; if (duty_out !== 15'd100) begin miscompares++; $display("FAIL dis_step got=%0d exp=100", duty_out); end
        cyc(4);
        vectors++; if (duty_out !== '0 || state !== ST_BRAKE) begin miscompares++; $display("FAIL dis_zero duty=%0d state=%0d exp 0/3", duty_out, state); end
        cyc(1);
        vectors++; if (state !== ST_IDLE || busy !== 1'b0 || dir_out !== 1'b0) begin miscompares++; $display("FAIL dis_idle state=%0d busy=%0b dir=%0b exp 0/0/0", state, busy, dir_out); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_redirect();
        test_reverse();
        test_stop_glitch();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
